// File: rtl/execute_stage_controller.sv
// execute_stage_controller
//   Sequences one instruction at a time through the execute stage. Single-cycle
//   ops are handed to a combinational executor; mul/div ops are started on an
//   external multi-cycle unit and aborted if it does not answer within
//   MD_TIMEOUT cycles. Results are held for the memory stage until accepted.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   id_valid/id_ready     instruction handshake from decode
//   id_is_muldiv, id_pc   instruction class and PC
//   ex_pc, exe_enable     latched PC and enable for the single-cycle executor
//   exe_done, alu_result  executor completion and result
//   jump_taken/target     executor branch outcome
//   md_start, md_abort    start/cancel pulses to the mul/div unit
//   md_done, md_result    mul/div completion and result
//   wb_valid/wb_ready     result handshake to memory stage (wb_result, wb_error)
//   redirect_valid/pc     one-cycle fetch redirect pulse
//   flush                 kills the in-flight instruction
//   busy, retire_count    controller not idle; retired instruction count
module execute_stage_controller #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic            id_is_muldiv,
    input  logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] ex_pc,
    output logic            exe_enable,
    input  logic            exe_done,
    input  logic [XLEN-1:0] alu_result,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    output logic            md_start,
    output logic            md_abort,
    input  logic            md_done,
    input  logic [XLEN-1:0] md_result,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_result,
    output logic            wb_error,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            flush,
    output logic            busy,
    output logic [31:0]     retire_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        MD_WAIT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] md_cnt;
    logic       redirect_q;
    logic       accept;
    logic       md_timeout_hit;
    logic       retire;

    always_comb begin
        state_next     = state;
        // A pending redirect is withdrawn if flush arrives in the same cycle.
        redirect_valid = redirect_q && !flush;
        id_ready       = ((state == IDLE) || ((state == DRAIN) && wb_ready))
                         && !redirect_valid && !flush;
        accept         = id_valid && id_ready;
        exe_enable     = (state == EXEC);
        md_start       = (state == MD_WAIT) && (md_cnt == '0);
        md_timeout_hit = (state == MD_WAIT) && !md_done
                         && (md_cnt == 8'(MD_TIMEOUT - 1));
        // Gated by reset so a reset arriving mid-wait never cancels the unit.
        md_abort       = reset && (state == MD_WAIT) && (flush || md_timeout_hit);
        wb_valid       = (state == DRAIN) && !flush;
        retire         = (state == DRAIN) && wb_ready && !flush;
        busy           = (state != IDLE);

        case (state)
            IDLE: begin
                if (accept) state_next = id_is_muldiv ? MD_WAIT : EXEC;
            end
            EXEC: begin
                if (exe_done) state_next = DRAIN;
            end
            MD_WAIT: begin
                if (md_done || md_timeout_hit) state_next = DRAIN;
            end
            DRAIN: begin
                if (wb_ready) begin
                    if (accept) state_next = id_is_muldiv ? MD_WAIT : EXEC;
                    else        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            ex_pc        <= '0;
            wb_result    <= '0;
            wb_error     <= 1'b0;
            redirect_q   <= 1'b0;
            redirect_pc  <= '0;
            md_cnt       <= '0;
            retire_count <= '0;
        end else begin
            state <= state_next;

            if (accept) ex_pc <= id_pc;

            redirect_q <= 1'b0;
            if ((state == EXEC) && exe_done && jump_taken && !flush) begin
                redirect_q  <= 1'b1;
                redirect_pc <= jump_target;
            end

            if (!flush) begin
                if ((state == EXEC) && exe_done) begin
                    wb_result <= alu_result;
                    wb_error  <= 1'b0;
                end else if ((state == MD_WAIT) && md_done) begin
                    wb_result <= md_result;
                    wb_error  <= 1'b0;
                end else if (md_timeout_hit) begin
                    wb_result <= '0;
                    wb_error  <= 1'b1;
                end
            end

            // Counter restarts on every entry, including straight from DRAIN.
            if ((state_next == MD_WAIT) && (state != MD_WAIT)) md_cnt <= '0;
            else if (state == MD_WAIT)                         md_cnt <= md_cnt + 8'd1;

            if (retire) retire_count <= retire_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_execute_stage_controller.sv
// tb_execute_stage_controller
//   Scenario tasks drive the controller just after each rising edge and check
//   outputs at the falling edge. Expected write-back results are queued when
//   an instruction is issued and compared whenever the DUT hands one off.
module tb_execute_stage_controller;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid;
    logic            id_ready;
    logic            id_is_muldiv;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] ex_pc;
    logic            exe_enable;
    logic            exe_done;
    logic [XLEN-1:0] alu_result;
    logic            jump_taken;
    logic [XLEN-1:0] jump_target;
    logic            md_start;
    logic            md_abort;
    logic            md_done;
    logic [XLEN-1:0] md_result;
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_result;
    logic            wb_error;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            busy;
    logic [31:0]     retire_count;

    logic            exe_hold;
    int unsigned     checks;
    int unsigned     failures;
    logic [31:0]     exp_retire;
    logic [XLEN:0]   sb[$];

    execute_stage_controller #(.XLEN(XLEN), .MD_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_is_muldiv(id_is_muldiv), .id_pc(id_pc), .ex_pc(ex_pc),
        .exe_enable(exe_enable), .exe_done(exe_done),
        .alu_result(alu_result), .jump_taken(jump_taken), .jump_target(jump_target),
        .md_start(md_start), .md_abort(md_abort),
        .md_done(md_done), .md_result(md_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_result(wb_result), .wb_error(wb_error),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .busy(busy), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Executor model: finishes in the cycle it is enabled unless held off.
    always_comb exe_done = exe_enable && !exe_hold;

    // Scoreboard: every accepted write-back must match the oldest queued result.
    always @(negedge clk) begin
        if (wb_valid && wb_ready) begin
            logic [XLEN:0] exp;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got result=%h error=%b, required no write-back",
                         wb_result, wb_error);
            end else begin
                exp = sb.pop_front();
                if ({wb_error, wb_result} !== exp) begin
                    failures++;
                    $display("FAIL sb_result: got error=%b result=%h, required error=%b result=%h",
                             wb_error, wb_result, exp[XLEN], exp[XLEN-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; id_valid = 1'b0; id_is_muldiv = 1'b0; id_pc = '0;
        alu_result = '0; jump_taken = 1'b0; jump_target = '0; md_done = 1'b0;
        md_result = '0; wb_ready = 1'b1; flush = 1'b0; exe_hold = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b required 0", busy); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid: got %b required 0", wb_valid); end
        checks++; if (wb_result !== '0) begin failures++; $display("FAIL rst_wb_result: got %h required 0", wb_result); end
        checks++; if (ex_pc !== '0) begin failures++; $display("FAIL rst_ex_pc: got %h required 0", ex_pc); end
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== '0) begin failures++; $display("FAIL rst_redirect: got %b/%h required 0/0", redirect_valid, redirect_pc); end
        checks++; if (retire_count !== 32'd0) begin failures++; $display("FAIL rst_retire: got %0d required 0", retire_count); end
        checks++; if (md_start !== 1'b0 || md_abort !== 1'b0) begin failures++; $display("FAIL rst_md: got start=%b abort=%b required 0/0", md_start, md_abort); end
        tick(); reset = 1'b1;
        exp_retire = 32'd0;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b required 1", id_ready); end
    endtask

    task automatic test_alu();
        tick(); id_valid = 1'b1; id_pc = 64'h1000; alu_result = 64'h2A; wb_ready = 1'b1;
        @(negedge clk);
        sb.push_back({1'b0, 64'h2A});
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL alu_accept: got %b required 1", id_ready); end
        tick(); id_valid = 1'b0;
        @(negedge clk);
        checks++; if (exe_enable !== 1'b1) begin failures++; $display("FAIL alu_exe_en: got %b required 1", exe_enable); end
        checks++; if (ex_pc !== 64'h1000) begin failures++; $display("FAIL alu_ex_pc: got %h required 1000", ex_pc); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_early_wb: got %b required 0", wb_valid); end
        tick();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid: got %b required 1", wb_valid); end
        exp_retire = exp_retire + 32'd1;
        tick();
        @(negedge clk);
        checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL alu_retire: got %0d required %0d", retire_count, exp_retire); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL alu_idle: got busy=%b required 0", busy); end
    endtask

    task automatic test_branch();
        tick(); id_valid = 1'b1; id_pc = 64'h1010; alu_result = 64'h55;
        jump_taken = 1'b1; jump_target = 64'h1040;
        @(negedge clk);
        sb.push_back({1'b0, 64'h55});
        tick(); id_valid = 1'b0;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL br_early: got %b required 0", redirect_valid); end
        tick();
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b1) begin failures++; $display("FAIL br_pulse: got %b required 1", redirect_valid); end
        checks++; if (redirect_pc !== 64'h1040) begin failures++; $display("FAIL br_pc: got %h required 1040", redirect_pc); end
        checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL br_ready: got %b required 0", id_ready); end
        exp_retire = exp_retire + 32'd1;
        tick(); jump_taken = 1'b0;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL br_single: got %b required 0", redirect_valid); end
        checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL br_retire: got %0d required %0d", retire_count, exp_retire); end
    endtask

    task automatic test_exec_stall();
        exe_hold = 1'b1;
        tick(); id_valid = 1'b1; id_pc = 64'h1100; alu_result = 64'h66;
        @(negedge clk);
        sb.push_back({1'b0, 64'h66});
        for (int i = 0; i < 2; i++) begin
            tick(); id_valid = 1'b0;
            @(negedge clk);
            checks++; if (exe_enable !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL stall_hold: got en=%b wb=%b required 1/0", exe_enable, wb_valid); end
        end
        tick(); exe_hold = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL stall_wb: got %b required 1", wb_valid); end
        exp_retire = exp_retire + 32'd1;
        tick();
    endtask

    task automatic test_muldiv();
        tick(); md_done = 1'b1; md_result = 64'hDEAD;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL md_stray: got busy=%b required 0", busy); end
        tick(); md_done = 1'b0; md_result = 64'h7; id_valid = 1'b1; id_is_muldiv = 1'b1; id_pc = 64'h1200;
        @(negedge clk);
        sb.push_back({1'b0, 64'h7});
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL md_stray_wb: got %b required 0", wb_valid); end
        tick(); id_valid = 1'b0; id_is_muldiv = 1'b0;
        @(negedge clk);
        checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL md_start: got %b required 1", md_start); end
        checks++; if (exe_enable !== 1'b0) begin failures++; $display("FAIL md_exe_en: got %b required 0", exe_enable); end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            checks++; if (md_start !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL md_wait: got start=%b wb=%b required 0/0", md_start, wb_valid); end
        end
        tick(); md_done = 1'b1;
        tick(); md_done = 1'b0;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_result !== 64'h7) begin failures++; $display("FAIL md_result: got %b/%h required 1/7", wb_valid, wb_result); end
        exp_retire = exp_retire + 32'd1;
        tick();
        @(negedge clk);
        checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL md_retire: got %0d required %0d", retire_count, exp_retire); end
    endtask

    task automatic test_timeout();
        tick(); id_valid = 1'b1; id_is_muldiv = 1'b1; id_pc = 64'h1300; md_result = 64'h99;
        @(negedge clk);
        sb.push_back({1'b1, 64'h0});
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 1) begin id_valid = 1'b0; id_is_muldiv = 1'b0; end
            @(negedge clk);
            checks++;
            if (md_abort !== (i == 64)) begin
                failures++;
                $display("FAIL to_abort cycle %0d: got %b required %b", i, md_abort, (i == 64));
            end
        end
        tick();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_error !== 1'b1 || wb_result !== '0) begin failures++; $display("FAIL to_wb: got %b/%b/%h required 1/1/0", wb_valid, wb_error, wb_result); end
        exp_retire = exp_retire + 32'd1;
        tick();
    endtask

    task automatic test_back_to_back();
        wb_ready = 1'b0;
        tick(); id_valid = 1'b1; id_pc = 64'h1400; alu_result = 64'h33;
        @(negedge clk);
        sb.push_back({1'b0, 64'h33});
        tick(); id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++; if (wb_valid !== 1'b1 || wb_result !== 64'h33) begin failures++; $display("FAIL bp_hold: got %b/%h required 1/33", wb_valid, wb_result); end
            checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL bp_ready: got %b required 0", id_ready); end
            checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL bp_retire: got %0d required %0d", retire_count, exp_retire); end
        end
        tick(); wb_ready = 1'b1; id_valid = 1'b1; id_pc = 64'h2000; alu_result = 64'h44;
        @(negedge clk);
        checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept: got %b required 1", id_ready); end
        sb.push_back({1'b0, 64'h44});
        exp_retire = exp_retire + 32'd1;
        tick(); id_valid = 1'b0;
        @(negedge clk);
        checks++; if (exe_enable !== 1'b1 || ex_pc !== 64'h2000) begin failures++; $display("FAIL b2b_exec: got %b/%h required 1/2000", exe_enable, ex_pc); end
        checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL b2b_retire1: got %0d required %0d", retire_count, exp_retire); end
        tick();
        exp_retire = exp_retire + 32'd1;
        tick();
        @(negedge clk);
        checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL b2b_retire2: got %0d required %0d", retire_count, exp_retire); end
    endtask

    task automatic test_flush();
        tick(); id_valid = 1'b1; id_pc = 64'h1500; alu_result = 64'h77; jump_taken = 1'b1; jump_target = 64'h1800;
        tick(); id_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++; if (id_ready !== 1'b0 || md_abort !== 1'b0) begin failures++; $display("FAIL fl_exec: got ready=%b abort=%b required 0/0", id_ready, md_abort); end
        tick(); flush = 1'b0; jump_taken = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL fl_idle: got busy=%b wb=%b redir=%b required 0/0/0", busy, wb_valid, redirect_valid); end
        checks++; if (retire_count !== exp_retire) begin failures++; $display("FAIL fl_retire: got %0d required %0d", retire_count, exp_retire); end
        tick(); id_valid = 1'b1; alu_result = 64'h88;
        tick(); id_valid = 1'b0;
        tick(); flush = 1'b1;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL fl_drain: got wb_valid=%b required 0", wb_valid); end
        tick(); flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || retire_count !== exp_retire) begin failures++; $display("FAIL fl_drain_retire: got busy=%b retire=%0d required 0/%0d", busy, retire_count, exp_retire); end
        tick(); id_valid = 1'b1; id_is_muldiv = 1'b1;
        tick(); id_valid = 1'b0; id_is_muldiv = 1'b0;
        tick(); flush = 1'b1;
        @(negedge clk);
        checks++; if (md_abort !== 1'b1) begin failures++; $display("FAIL fl_md_abort: got %b required 1", md_abort); end
        tick(); flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || md_abort !== 1'b0) begin failures++; $display("FAIL fl_md_idle: got busy=%b abort=%b required 0/0", busy, md_abort); end
    endtask

    task automatic test_reset_mid();
        tick(); id_valid = 1'b1; id_is_muldiv = 1'b1; id_pc = 64'h1600;
        tick(); id_valid = 1'b0; id_is_muldiv = 1'b0;
        tick();
        tick(); reset = 1'b0; flush = 1'b1;
        @(negedge clk);
        checks++; if (md_abort !== 1'b0) begin failures++; $display("FAIL rm_abort: got %b required 0", md_abort); end
        tick(); flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ex_pc !== '0 || md_abort !== 1'b0) begin failures++; $display("FAIL rm_state: got busy=%b ex_pc=%h abort=%b required 0/0/0", busy, ex_pc, md_abort); end
        checks++; if (retire_count !== 32'd0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL rm_counts: got retire=%0d redir=%b required 0/0", retire_count, redirect_valid); end
        tick(); reset = 1'b1; exp_retire = 32'd0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_after: got busy=%b required 0", busy); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_retire = 32'd0;
        test_reset();
        test_alu();
        test_branch();
        test_exec_stall();
        test_muldiv();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending results required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/execute_stage_controller.md
EXECUTE_STAGE_CONTROLLER -- requirements
Module: execute_stage_controller

Interface
REQ-001 Parameter XLEN, default 64, datapath/PC width.
REQ-002 Parameter MD_TIMEOUT, default 64, max cycles waiting for md_done before abort (range 2..255).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-005 id_valid  in  1  decode presents an instruction.
REQ-006 id_ready  out  1  controller accepts instruction this cycle.
REQ-007 id_is_muldiv  in  1  instruction is multi-cycle mul/div.
REQ-008 id_pc  in  XLEN  PC of presented instruction.
REQ-009 ex_pc  out  XLEN  latched PC driven to single-cycle executor.
REQ-010 exe_enable  out  1  enables single-cycle executor.
REQ-011 exe_done  in  1  executor finished (combinational from exe_enable).
REQ-012 alu_result  in  XLEN  executor result; jump_taken in 1; jump_target in XLEN.
REQ-013 md_start  out  1  one-cycle start pulse to mul/div unit; md_abort out 1 one-cycle cancel pulse.
REQ-014 md_done  in  1  mul/div result valid; md_result in XLEN.
REQ-015 wb_valid  out  1 / wb_ready  in  1 / wb_result  out  XLEN / wb_error  out  1  result handshake to memory stage.
REQ-016 redirect_valid  out  1  one-cycle pulse; redirect_pc out XLEN target.
REQ-017 flush  in  1  kill in-flight instruction; busy out 1 state != IDLE; retire_count out 32.

Function
REQ-018 States SHALL be IDLE, EXEC, MD_WAIT, DRAIN, encoded and registered.
REQ-019 id_ready SHALL equal (IDLE or (DRAIN and wb_ready)) and not redirect_valid and not flush.
REQ-020 On id_valid&&id_ready: latch id_pc into ex_pc; next state MD_WAIT if id_is_muldiv else EXEC.
REQ-021 EXEC: exe_enable=1; on exe_done capture alu_result into wb_result, wb_error=0, go DRAIN.
REQ-022 EXEC with exe_done and jump_taken: redirect_valid=1 and redirect_pc=jump_target in the first DRAIN cycle only.
REQ-023 EXEC without exe_done SHALL remain in EXEC holding exe_enable.
REQ-024 MD_WAIT: md_start=1 exactly in the first MD_WAIT cycle; wait counter cleared on entry, incremented per cycle.
REQ-025 MD_WAIT with md_done: capture md_result, wb_error=0, go DRAIN; md_done outside MD_WAIT SHALL be ignored.
REQ-026 MD_WAIT counter reaching MD_TIMEOUT without md_done: md_abort pulse, wb_result=0, wb_error=1, go DRAIN.
REQ-027 DRAIN: wb_valid=1, wb_result/wb_error stable until wb_ready; on wb_ready retire_count increments (wraps 0xFFFFFFFF->0).
REQ-028 DRAIN with wb_ready: go IDLE, or directly EXEC/MD_WAIT if a new instruction is accepted same cycle.
REQ-029 Latency: accept at T -> exe_enable T+1 -> wb_valid T+2 (single-cycle op, exe_done immediate).
REQ-030 flush SHALL override all transitions: next state IDLE, wb_valid=0, no redirect, no retire increment; md_abort=1 if flushed in MD_WAIT.
REQ-031 flush coincident with exe_done, md_done or wb_ready: flush wins, result discarded, retire_count unchanged.
REQ-032 exe_enable, md_start, md_abort, redirect_valid SHALL never be asserted in IDLE.

Reset
REQ-033 reset low at clk edge: state IDLE, wb_valid=0, wb_result=0, wb_error=0, ex_pc=0, redirect_valid=0, redirect_pc=0, md_start=0, md_abort=0, counters=0, retire_count=0.
REQ-034 reset mid-operation (any state) SHALL abandon work without md_abort or redirect pulse; reset overrides flush.
REQ-035 Outputs SHALL reach reset values the cycle after reset is first sampled low and hold while low.

Verification
REQ-036 ALU op, id_pc=0x1000, wb_ready=1, exe_done immediate, alu_result=0x2A -> exe_enable at T+1, wb_valid T+2 with 0x2A, retire_count=1.
REQ-037 Taken branch, jump_target=0x1040 -> redirect_valid single pulse at T+2, redirect_pc=0x1040, id_ready=0 that cycle.
REQ-038 Mul/div, md_done 5 cycles after md_start, md_result=0x7 -> md_start one pulse, wb_result=0x7 one cycle after md_done.
REQ-039 Mul/div, md_done never, MD_TIMEOUT=64 -> md_abort after 64 MD_WAIT cycles, wb_error=1, wb_result=0.
REQ-040 wb_ready low 3 cycles in DRAIN -> wb_result stable, id_ready=0, no retire; then back-to-back accept on wb_ready.
REQ-041 flush asserted with exe_done and jump_taken -> no redirect, wb_valid=0, IDLE next; reset low in MD_WAIT -> IDLE, no md_abort.
